// File: rtl/memory_slave_bram.sv
// memory_slave_bram
//   Block-RAM-backed MemoryBus slave. This block accepts read and write requests
//   and performs them against an on-chip array of WORDS 24-bit words. Tagged
//   responses come back through a show-ahead response FIFO. Requests are accepted
//   only while a credit is free, so the master may stall on response-take
//   without losing any data.
//
//   Optional feature macro: MEMORY_SLAVE_WRITE_ACK_EN.
//   When it is defined, every write also returns a response, and that response
//   uses a credit.
//
// Ports
//   clock, reset                    system clock, synchronous active-high reset
//   msAddress_i/msData_i/msID_i     request word address, write data, tag
//   msWrite_i/msValid_i             request is a write / request present
//   msTaken_o                       request accepted this cycle (with msValid_i)
//   smData_o/smID_o/smValid_o       response data, tag, present (FIFO head)
//   smTaken_i                       response consumed (with smValid_o)
module memory_slave_bram #(
    parameter int unsigned WORDS        = 4096,
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] msAddress_i,
    input  logic [23:0] msData_i,
    input  logic [7:0]  msID_i,
    input  logic        msWrite_i,
    input  logic        msValid_i,
    output logic        msTaken_o,
    output logic [23:0] smData_o,
    output logic [7:0]  smID_o,
    output logic        smValid_o,
    input  logic        smTaken_i
);
    localparam int AW = $clog2(WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;   // holds inflight (<=2) + occupancy (<=DEPTH)

    typedef struct packed {
        logic [23:0] data;
        logic [7:0]  id;
    } resp_t;

    logic [23:0] mem [WORDS];
    resp_t       fifo_q [FIFO_DEPTH];

    logic [31:0] index;
    logic        in_range, accept, resp_req, push, pop;
    logic [CW-1:0] credits;

    // Stage 1: request side registered at the acceptance edge, RAM read issued
    logic        s1_vld_q, s1_write_q, s1_range_q;
    logic [7:0]  s1_id_q;
    logic [23:0] s1_wdata_q, rd_q;
    // Stage 2: final response word, pushed into the FIFO at the next edge
    logic        s2_vld_q;
    resp_t       s2_q, s2_d;

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] occ_q;

    // The subtraction wraps below BASE_ADDRESS, so a single compare covers both sides.
    assign index    = msAddress_i - BASE_ADDRESS;
    assign in_range = index < WORDS;

`ifdef MEMORY_SLAVE_WRITE_ACK_EN
    assign resp_req = 1'b1;
`else
    assign resp_req = !msWrite_i;
`endif

    assign credits   = CW'(s1_vld_q) + CW'(s2_vld_q) + occ_q;
    assign msTaken_o = !reset && (credits < CW'(FIFO_DEPTH));
    assign accept    = msValid_i && msTaken_o;

    assign push = s2_vld_q;
    assign pop  = smValid_o && smTaken_i;

    // Write-back and read share the acceptance edge. A read one cycle after a
    // write therefore sees the new word, and a read that is followed by a write
    // still returns the old word.
    always_ff @(posedge clock) begin
        if (accept && msWrite_i && in_range)
            mem[index[AW-1:0]] <= msData_i;
        if (accept)
            rd_q <= mem[index[AW-1:0]];
    end

    always_ff @(posedge clock) begin
        if (accept) begin
            s1_write_q <= msWrite_i;
            s1_range_q <= in_range;
            s1_id_q    <= msID_i;
            s1_wdata_q <= in_range ? msData_i : 24'h000000;
        end
    end

    always_comb begin
        s2_d.id   = s1_id_q;
        s2_d.data = s1_write_q ? s1_wdata_q : (s1_range_q ? rd_q : 24'h000000);
    end

    always_ff @(posedge clock) begin
        if (s1_vld_q)
            s2_q <= s2_d;
        if (push)
            fifo_q[wr_ptr_q] <= s2_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            s1_vld_q <= accept && resp_req;
            s2_vld_q <= s1_vld_q;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // The head is masked so that an empty or reset FIFO presents zeros.
    assign smValid_o = occ_q != '0;
    assign smData_o  = smValid_o ? fifo_q[rd_ptr_q].data : 24'h000000;
    assign smID_o    = smValid_o ? fifo_q[rd_ptr_q].id   : 8'h00;

endmodule

// File: tb/tb_memory_slave_bram.sv
module tb_memory_slave_bram;
    localparam int unsigned WORDS = 4096;
    localparam logic [31:0] BASE  = 32'h0001_0000;
`ifdef MEMORY_SLAVE_WRITE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] msAddress = '0;
    logic [23:0] msData = '0;
    logic [7:0]  msID = '0;
    logic        msWrite = 1'b0, msValid = 1'b0, smTaken = 1'b0;
    logic        msTaken, smValid;
    logic [23:0] smData;
    logic [7:0]  smID;

    int checks = 0, errors = 0, cyc = 0;
    logic [31:0] exp_q [$];

    memory_slave_bram #(.WORDS(WORDS), .BASE_ADDRESS(BASE), .FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .msAddress_i(msAddress), .msData_i(msData), .msID_i(msID),
        .msWrite_i(msWrite), .msValid_i(msValid), .msTaken_o(msTaken),
        .smData_o(smData), .smID_o(smID), .smValid_o(smValid), .smTaken_i(smTaken)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response monitor: pops the scoreboard whenever a response is taken.
    always @(negedge clock) begin
        if (!reset && smValid && smTaken) begin
            if (exp_q.size() == 0) chk("unexpected_resp", {smData, smID}, 32'hxxxxxxxx);
            else chk("resp", {smData, smID}, exp_q.pop_front());
        end
    end

    // Called just after a rising edge; returns just after the acceptance edge.
    task automatic req(input logic [31:0] a, input logic [23:0] d, input logic [7:0] id,
                       input logic w, input logic [23:0] exp_d);
        int n = 0;
        msAddress = a; msData = d; msID = id; msWrite = w; msValid = 1'b1;
        @(negedge clock);
        while (!msTaken && n < 50) begin n++; @(negedge clock); end
        if (!msTaken) chk("accept_timeout", 32'd0, 32'd1);
        else if (!w || ACK) exp_q.push_back({exp_d, id});
        @(posedge clock); #1;
        msValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        smTaken = 1'b1;
        while ((exp_q.size() != 0 || smValid) && n < 100) begin
            @(posedge clock); #1; n++;
        end
        if (n >= 100) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        smTaken = 1'b0;
    endtask

    initial begin
        int acc, c0;
        // reset state
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_msTaken", 32'(msTaken), 32'd0);
        chk("rst_smValid", 32'(smValid), 32'd0);
        chk("rst_smData_id", {smData, smID}, 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("post_rst_msTaken", 32'(msTaken), 32'd1);
        @(posedge clock); #1;

        // write then read, with latency check
        req(BASE + 5, 24'hABCDEF, 8'h03, 1'b1, 24'hABCDEF);
        req(BASE + 5, 24'h000000, 8'h07, 1'b0, 24'hABCDEF);
        @(negedge clock); chk("lat_e0", 32'(smValid), 32'd0);
        @(negedge clock); chk("lat_e1", 32'(smValid), 32'(ACK));
        @(negedge clock); chk("lat_e2", 32'(smValid), 32'd1);
        @(posedge clock); #1;
        drain();

        // full: 6 attempts with smTaken low, exactly 4 accepted
        msAddress = BASE + 5; msWrite = 1'b0; msValid = 1'b1; acc = 0;
        for (int i = 0; i < 6; i++) begin
            msID = 8'(8'h20 + acc);
            @(negedge clock);
            if (msTaken) begin exp_q.push_back({24'hABCDEF, 8'(8'h20 + acc)}); acc++; end
            @(posedge clock); #1;
        end
        msValid = 1'b0;
        chk("full_accepts", 32'(acc), 32'd4);
        @(negedge clock); chk("full_msTaken", 32'(msTaken), 32'd0);
        @(posedge clock); #1 smTaken = 1'b1;
        @(posedge clock); #1 smTaken = 1'b0;
        @(negedge clock); chk("after_pop_msTaken", 32'(msTaken), 32'd1);
        @(posedge clock); #1;
        drain();

        // back-to-back writes and reads with smTaken held high
        smTaken = 1'b1;
        for (int i = 0; i < 8; i++)
            req(BASE + 32'(i), 24'h100000 + 24'(i), 8'(8'h40 + i), 1'b1, 24'h100000 + 24'(i));
        c0 = cyc;
        for (int i = 0; i < 8; i++)
            req(BASE + 32'(i), 24'h000000, 8'(i), 1'b0, 24'h100000 + 24'(i));
        chk("b2b_cycles", 32'(cyc - c0), 32'd8);
        drain();

        // out of range
        smTaken = 1'b1;
        req(BASE + WORDS, 24'h000000, 8'h50, 1'b0, 24'h000000);
        req(BASE - 1, 24'h000000, 8'h51, 1'b0, 24'h000000);
        req(BASE + WORDS, 24'h123456, 8'h52, 1'b1, 24'h000000);
        req(BASE, 24'h000000, 8'h53, 1'b0, 24'h100000);

        // read-after-write on consecutive cycles
        req(BASE + 1, 24'h5A5A5A, 8'h60, 1'b1, 24'h5A5A5A);
        req(BASE + 1, 24'h000000, 8'h61, 1'b0, 24'h5A5A5A);
        drain();

        // reset with three responses queued
        req(BASE + 2, 24'h0, 8'h70, 1'b0, 24'h100002);
        req(BASE + 3, 24'h0, 8'h71, 1'b0, 24'h100003);
        req(BASE + 4, 24'h0, 8'h72, 1'b0, 24'h100004);
        repeat (3) @(negedge clock);
        chk("queued_smValid", 32'(smValid), 32'd1);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1;
        exp_q.delete();
        @(negedge clock);
        chk("midrst_smValid", 32'(smValid), 32'd0);
        chk("midrst_msTaken", 32'(msTaken), 32'd0);
        chk("midrst_smData_id", {smData, smID}, 32'd0);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("after_rst_msTaken", 32'(msTaken), 32'd1);
        chk("after_rst_smValid", 32'(smValid), 32'd0);
        @(posedge clock); #1;

        // array survives reset
        req(BASE + 1, 24'h000000, 8'h80, 1'b0, 24'h5A5A5A);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
